// File: rtl/bram_loader_pkg.sv
// ---------------------------------------------------------------------------
// bram_loader_pkg
// Shared constants for the BRAM loader: default sizing, word/byte widths,
// FSM state encoding and a small address helper.
// ---------------------------------------------------------------------------
package bram_loader_pkg;

    localparam int BRAMWORDS_DEF       = 4096;
    localparam int CORE_RST_CYCLES_DEF = 5;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 13;   // wide enough to hold a word count of 4096
    localparam int WE_W   = 4;

    // FSM state encoding (plain constants so legacy tools can consume them)
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_LOAD_DATA = 3'd1;
    localparam state_t ST_LOAD_INST = 3'd2;
    localparam state_t ST_RST_CORE  = 3'd3;
    localparam state_t ST_DONE      = 3'd4;

    // Byte address of a word index (word-aligned, zero-extended).
    function automatic logic [WORD_W-1:0] word_addr(input logic [CNT_W-1:0] idx);
        return {{(WORD_W-CNT_W-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/bram_loader_byte_to_word_packer.sv
// ---------------------------------------------------------------------------
// bram_loader_byte_to_word_packer
// Assembles a little-endian byte stream into 32-bit words.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   clear_i         : drop any partial word and restart at byte 0
//   byte_valid_i    : a byte is accepted this cycle (upstream valid & ready)
//   byte_i          : accepted byte
//   word_valid_o    : combinational pulse, high in the cycle the 4th byte
//                     of a word is accepted
//   word_o          : completed word, valid while word_valid_o is high
// ---------------------------------------------------------------------------
module bram_loader_byte_to_word_packer
    import bram_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] partial_q,  partial_d;

    // The 4th byte is never stored: it is merged straight into word_o so
    // the word is available without an extra bubble.
    assign word_valid_o = byte_valid_i && (byte_cnt_q == 2'd3);
    assign word_o       = {byte_i, partial_q};

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        partial_d  = partial_q;
        if (clear_i) begin
            byte_cnt_d = 2'd0;
            partial_d  = 24'd0;
        end else if (byte_valid_i) begin
            byte_cnt_d = byte_cnt_q + 2'd1;   // wraps 3 -> 0
            case (byte_cnt_q)
                2'd0:    partial_d[7:0]   = byte_i;
                2'd1:    partial_d[15:8]  = byte_i;
                2'd2:    partial_d[23:16] = byte_i;
                default: partial_d        = partial_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q <= 2'd0;
            partial_q  <= 24'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            partial_q  <= partial_d;
        end
    end

endmodule

// File: rtl/bram_loader.sv
// ---------------------------------------------------------------------------
// bram_loader
// Streams bytes into the Data RAM then the Inst RAM of an RV32 core through
// their debug write ports, then pulses the core reset.
//   CPU_CLK, CPU_RST_N         : clock, asynchronous active-low reset
//   start, data_words,
//   inst_words                 : load request and word counts (IDLE/DONE only)
//   s_data, s_valid, s_ready   : byte stream; a byte transfers on a rising
//                                edge where s_valid and s_ready are both high.
//                                s_valid may drop at any time; s_ready does not
//                                depend on s_valid.
//   CPU_Debug_{Data,Inst}RAM_* : word write ports (A2 byte address, WD2 data,
//                                WE2 byte enables), registered
//   core_rst                   : active-high core reset after loading
//   busy, done, err            : status
//   dbg_state                  : current FSM state
// Parameters: BRAMWORDS (words per BRAM), CORE_RST_CYCLES (>= 1).
// ---------------------------------------------------------------------------
module bram_loader
    import bram_loader_pkg::*;
#(
    parameter int BRAMWORDS       = BRAMWORDS_DEF,
    parameter int CORE_RST_CYCLES = CORE_RST_CYCLES_DEF
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST_N,
    input  logic              start,
    input  logic [CNT_W-1:0]  data_words,
    input  logic [CNT_W-1:0]  inst_words,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] CPU_Debug_DataRAM_A2,
    output logic [WORD_W-1:0] CPU_Debug_DataRAM_WD2,
    output logic [WE_W-1:0]   CPU_Debug_DataRAM_WE2,
    output logic [WORD_W-1:0] CPU_Debug_InstRAM_A2,
    output logic [WORD_W-1:0] CPU_Debug_InstRAM_WD2,
    output logic [WE_W-1:0]   CPU_Debug_InstRAM_WE2,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    localparam logic [31:0] RST_LAST = 32'(CORE_RST_CYCLES - 1);

    state_t            state_q,      state_d;
    logic [CNT_W-1:0]  data_words_q, data_words_d;
    logic [CNT_W-1:0]  inst_words_q, inst_words_d;
    logic [CNT_W-1:0]  idx_q,        idx_d;
    logic [31:0]       rst_cnt_q,    rst_cnt_d;
    logic              err_q,        err_d;
    logic [WORD_W-1:0] d_a_q,  d_a_d,  d_wd_q, d_wd_d;
    logic [WORD_W-1:0] i_a_q,  i_a_d,  i_wd_q, i_wd_d;
    logic [WE_W-1:0]   d_we_q, d_we_d, i_we_q, i_we_d;

    logic              fire;
    logic              pack_clear;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic              too_big;
    logic              last_word;
    logic [CNT_W-1:0]  cur_words;

    assign s_ready   = (state_q == ST_LOAD_DATA) || (state_q == ST_LOAD_INST);
    assign fire      = s_valid && s_ready;
    assign busy      = s_ready || (state_q == ST_RST_CORE);
    assign done      = (state_q == ST_DONE);
    assign core_rst  = (state_q == ST_RST_CORE);
    assign err       = err_q;
    assign dbg_state = state_q;

    assign too_big   = ({19'd0, data_words} > 32'(BRAMWORDS)) ||
                       ({19'd0, inst_words} > 32'(BRAMWORDS));
    assign cur_words = (state_q == ST_LOAD_INST) ? inst_words_q : data_words_q;
    assign last_word = word_valid && ((idx_q + 13'd1) == cur_words);

    bram_loader_byte_to_word_packer u_packer (
        .clk_i        (CPU_CLK),
        .rst_ni       (CPU_RST_N),
        .clear_i      (pack_clear),
        .byte_valid_i (fire),
        .byte_i       (s_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d      = state_q;
        data_words_d = data_words_q;
        inst_words_d = inst_words_q;
        idx_d        = idx_q;
        rst_cnt_d    = rst_cnt_q;
        err_d        = err_q;
        d_a_d        = d_a_q;
        d_wd_d       = d_wd_q;
        i_a_d        = i_a_q;
        i_wd_d       = i_wd_q;
        d_we_d       = '0;
        i_we_d       = '0;
        pack_clear   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (too_big) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        err_d        = 1'b0;
                        data_words_d = data_words;
                        inst_words_d = inst_words;
                        idx_d        = '0;
                        rst_cnt_d    = '0;
                        pack_clear   = 1'b1;
                        if (data_words != '0)      state_d = ST_LOAD_DATA;
                        else if (inst_words != '0) state_d = ST_LOAD_INST;
                        else                       state_d = ST_RST_CORE;
                    end
                end
            end
            // The state moves on the same edge that accepts the final byte,
            // so the write cycle already shows the next region's s_ready.
            ST_LOAD_DATA: begin
                if (word_valid) begin
                    d_we_d = '1;
                    d_wd_d = word;
                    d_a_d  = word_addr(idx_q);
                    if (last_word) begin
                        idx_d   = '0;
                        state_d = (inst_words_q != '0) ? ST_LOAD_INST : ST_RST_CORE;
                    end else begin
                        idx_d = idx_q + 13'd1;
                    end
                end
            end
            ST_LOAD_INST: begin
                if (word_valid) begin
                    i_we_d = '1;
                    i_wd_d = word;
                    i_a_d  = word_addr(idx_q);
                    if (last_word) begin
                        idx_d   = '0;
                        state_d = ST_RST_CORE;
                    end else begin
                        idx_d = idx_q + 13'd1;
                    end
                end
            end
            ST_RST_CORE: begin
                if (rst_cnt_q == RST_LAST) state_d   = ST_DONE;
                else                       rst_cnt_d = rst_cnt_q + 32'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state_q      <= ST_IDLE;
            data_words_q <= '0;
            inst_words_q <= '0;
            idx_q        <= '0;
            rst_cnt_q    <= '0;
            err_q        <= 1'b0;
            d_a_q        <= '0;
            d_wd_q       <= '0;
            d_we_q       <= '0;
            i_a_q        <= '0;
            i_wd_q       <= '0;
            i_we_q       <= '0;
        end else begin
            state_q      <= state_d;
            data_words_q <= data_words_d;
            inst_words_q <= inst_words_d;
            idx_q        <= idx_d;
            rst_cnt_q    <= rst_cnt_d;
            err_q        <= err_d;
            d_a_q        <= d_a_d;
            d_wd_q       <= d_wd_d;
            d_we_q       <= d_we_d;
            i_a_q        <= i_a_d;
            i_wd_q       <= i_wd_d;
            i_we_q       <= i_we_d;
        end
    end

    assign CPU_Debug_DataRAM_A2  = d_a_q;
    assign CPU_Debug_DataRAM_WD2 = d_wd_q;
    assign CPU_Debug_DataRAM_WE2 = d_we_q;
    assign CPU_Debug_InstRAM_A2  = i_a_q;
    assign CPU_Debug_InstRAM_WD2 = i_wd_q;
    assign CPU_Debug_InstRAM_WE2 = i_we_q;

endmodule

// File: tb/tb_bram_loader.sv
module tb_bram_loader;

    logic        CPU_CLK;
    logic        CPU_RST_N;
    logic        start;
    logic [12:0] data_words;
    logic [12:0] inst_words;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] DataA2, DataWD2, InstA2, InstWD2;
    logic [3:0]  DataWE, InstWE;
    logic        core_rst, busy, done, err;
    logic [2:0]  dbg_state;

    bram_loader dut (
        .CPU_CLK               (CPU_CLK),
        .CPU_RST_N             (CPU_RST_N),
        .start                 (start),
        .data_words            (data_words),
        .inst_words            (inst_words),
        .s_data                (s_data),
        .s_valid               (s_valid),
        .s_ready               (s_ready),
        .CPU_Debug_DataRAM_A2  (DataA2),
        .CPU_Debug_DataRAM_WD2 (DataWD2),
        .CPU_Debug_DataRAM_WE2 (DataWE),
        .CPU_Debug_InstRAM_A2  (InstA2),
        .CPU_Debug_InstRAM_WD2 (InstWD2),
        .CPU_Debug_InstRAM_WE2 (InstWE),
        .core_rst              (core_rst),
        .busy                  (busy),
        .done                  (done),
        .err                   (err),
        .dbg_state             (dbg_state)
    );

    // ---------------- clock ----------------
    initial CPU_CLK = 1'b0;
    always #5 CPU_CLK = ~CPU_CLK;

    int cyc = 0;
    always @(posedge CPU_CLK) cyc <= cyc + 1;

    // ---------------- write monitor (observations only) ----------------
    typedef struct {
        logic        port;   // 0 = Data, 1 = Inst
        logic [3:0]  we;
        logic [3:0]  other;
        logic [31:0] a;
        logic [31:0] wd;
        int          cyc;
    } wr_t;

    wr_t wr_q[$];
    int  core_rst_total = 0;
    int  sready_total   = 0;

    always @(negedge CPU_CLK) begin
        if (DataWE != 4'h0) wr_q.push_back('{1'b0, DataWE, InstWE, DataA2, DataWD2, cyc});
        if (InstWE != 4'h0) wr_q.push_back('{1'b1, InstWE, DataWE, InstA2, InstWD2, cyc});
        if (core_rst) core_rst_total = core_rst_total + 1;
        if (s_ready)  sready_total   = sready_total + 1;
    end

    // ---------------- scoreboard ----------------
    logic [64:0] exp_q[$];   // {port, A2, WD2}
    int n_checks = 0;
    int n_fail   = 0;
    int start_cyc;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_writes(input int base);
        wr_t w;
        logic [64:0] e;
        chk("n_writes", 65'(wr_q.size() - base), 65'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < wr_q.size()) begin
                e = exp_q[i];
                w = wr_q[base + i];
                chk("wr_port", 65'(w.port), 65'(e[64]));
                chk("wr_addr", 65'(w.a), 65'(e[63:32]));
                chk("wr_data", 65'(w.wd), 65'(e[31:0]));
                chk("wr_we", 65'(w.we), 65'(4'hF));
                chk("wr_other_we", 65'(w.other), 65'(4'h0));
            end
        end
        exp_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start(input logic [12:0] dw, input logic [12:0] iw);
        @(posedge CPU_CLK); #1;
        start = 1'b1; data_words = dw; inst_words = iw;
        @(posedge CPU_CLK); #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        s_valid = 1'b1;
        s_data  = b;
        guard   = 0;
        while (!s_ready && guard < 100) begin
            @(posedge CPU_CLK); #1;
            guard++;
        end
        if (!s_ready) chk("s_ready_timeout", 65'(s_ready), 65'(1));
        @(posedge CPU_CLK); #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CPU_CLK); #1;
        end
    endtask

    task automatic wait_done(input int limit);
        int g;
        g = 0;
        while (!done && g < limit) begin
            @(posedge CPU_CLK); #1;
            g++;
        end
        chk("done_timeout", 65'(done), 65'(1));
    endtask

    // ---------------- directed sequence ----------------
    int wb, cb, sb;

    initial begin
        CPU_RST_N = 1'b0; start = 1'b0; data_words = '0; inst_words = '0;
        s_data = '0; s_valid = 1'b0;
        repeat (2) @(posedge CPU_CLK); #1;

        // reset state
        chk("rst_status", 65'({s_ready, busy, done, err, core_rst, dbg_state}), 65'(0));
        chk("rst_we", 65'({DataWE, InstWE}), 65'(0));
        chk("rst_data_port", 65'({DataA2, DataWD2}), 65'(0));
        chk("rst_inst_port", 65'({InstA2, InstWD2}), 65'(0));
        @(negedge CPU_CLK) CPU_RST_N = 1'b1;

        // 2 data words + 1 inst word, contiguous stream
        wb = wr_q.size(); cb = core_rst_total;
        pulse_start(13'd2, 13'd1);
        chk("load_flags", 65'({busy, s_ready, done, err}), 65'(4'b1100));
        chk("load_state", 65'(dbg_state), 65'(3'd1));
        for (int i = 1; i <= 12; i++) send_byte(i[7:0]);
        wait_done(50);
        if (wr_q.size() > wb) chk("lat_contig", 65'(wr_q[wb].cyc - start_cyc), 65'(4));
        exp_q.push_back({1'b0, 32'h0, 32'h04030201});
        exp_q.push_back({1'b0, 32'h4, 32'h08070605});
        exp_q.push_back({1'b1, 32'h0, 32'h0C0B0A09});
        check_writes(wb);
        chk("core_rst_len", 65'(core_rst_total - cb), 65'(5));
        chk("done_flags", 65'({busy, done, err, core_rst, s_ready}), 65'(5'b01000));
        chk("hold_data", 65'({DataA2, DataWD2}), {33'h0, 32'h08070605} | (65'h4 << 32));
        chk("hold_inst", 65'({InstA2, InstWD2}), 65'(32'h0C0B0A09));

        // zero words: straight to core reset
        wb = wr_q.size(); cb = core_rst_total; sb = sready_total;
        pulse_start(13'd0, 13'd0);
        chk("zero_state", 65'({dbg_state, core_rst, busy}), 65'({3'd3, 1'b1, 1'b1}));
        wait_done(50);
        check_writes(wb);
        chk("zero_sready", 65'(sready_total - sb), 65'(0));
        chk("zero_core_rst_len", 65'(core_rst_total - cb), 65'(5));

        // oversize request, then a normal one clears err
        wb = wr_q.size();
        pulse_start(13'd4097, 13'd1);
        chk("err_flags", 65'({err, busy, done, s_ready}), 65'(4'b1000));
        chk("err_state", 65'(dbg_state), 65'(3'd0));
        idle(5);
        check_writes(wb);
        pulse_start(13'd1, 13'd1);
        chk("err_cleared", 65'({err, busy}), 65'(2'b01));
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        wait_done(50);
        exp_q.push_back({1'b0, 32'h0, 32'h44332211});
        exp_q.push_back({1'b1, 32'h0, 32'h88776655});
        check_writes(wb);

        // stall of 3 cycles after byte 2 delays the write by 3 cycles
        wb = wr_q.size();
        pulse_start(13'd1, 13'd0);
        send_byte(8'h01); send_byte(8'h02);
        idle(3);
        send_byte(8'h03); send_byte(8'h04);
        wait_done(50);
        if (wr_q.size() > wb) chk("lat_stall", 65'(wr_q[wb].cyc - start_cyc), 65'(7));
        exp_q.push_back({1'b0, 32'h0, 32'h04030201});
        check_writes(wb);

        // reset mid-load after 6 of 8 bytes
        wb = wr_q.size();
        pulse_start(13'd2, 13'd0);
        for (int i = 0; i < 6; i++) send_byte(8'h21 + i[7:0]);
        exp_q.push_back({1'b0, 32'h0, 32'h24232221});
        check_writes(wb);
        #2 CPU_RST_N = 1'b0;
        #1;
        chk("mid_rst_status", 65'({s_ready, busy, done, err, core_rst, dbg_state}), 65'(0));
        chk("mid_rst_we", 65'({DataWE, InstWE}), 65'(0));
        chk("mid_rst_data_port", 65'({DataA2, DataWD2}), 65'(0));
        chk("mid_rst_inst_port", 65'({InstA2, InstWD2}), 65'(0));
        start = 1'b1; data_words = 13'd1; inst_words = 13'd0;
        @(negedge CPU_CLK) CPU_RST_N = 1'b1;
        @(posedge CPU_CLK); #1;
        start = 1'b0;
        chk("first_edge_start", 65'({busy, dbg_state}), 65'({1'b1, 3'd1}));
        wb = wr_q.size();
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        wait_done(50);
        exp_q.push_back({1'b0, 32'h0, 32'hD4C3B2A1});
        check_writes(wb);

        // full 4096-word data region, then region switch to inst
        wb = wr_q.size();
        pulse_start(13'd4096, 13'd1);
        chk("full_accept", 65'({err, busy}), 65'(2'b01));
        for (int i = 0; i < 16384; i++) send_byte(i[7:0]);
        chk("full_switch_state", 65'(dbg_state), 65'(3'd2));
        send_byte(8'h5A); send_byte(8'h5B); send_byte(8'h5C); send_byte(8'h5D);
        wait_done(50);
        chk("full_n_writes", 65'(wr_q.size() - wb), 65'(4097));
        if (wr_q.size() >= wb + 4097) begin
            chk("full_first", {wr_q[wb].port, wr_q[wb].a, wr_q[wb].wd},
                {1'b0, 32'h0, 32'h03020100});
            chk("full_last_data", {wr_q[wb+4095].port, wr_q[wb+4095].a, wr_q[wb+4095].wd},
                {1'b0, 32'h3FFC, 32'hFFFEFDFC});
            chk("full_inst", {wr_q[wb+4096].port, wr_q[wb+4096].a, wr_q[wb+4096].wd},
                {1'b1, 32'h0, 32'h5D5C5B5A});
        end
        chk("full_hold_a2", 65'(DataA2), 65'(32'h3FFC));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_loader.md
BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 Parameter BRAMWORDS, default 4096, words (32-bit) per BRAM.
REQ-002 Parameter CORE_RST_CYCLES, default 5, cycles core reset is held after loading.
REQ-003 CPU_CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 CPU_RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  single-cycle request to begin a load; sampled only in IDLE/DONE.
REQ-006 data_words  in  13  Data RAM words to load; latched on accepted start.
REQ-007 inst_words  in  13  Inst RAM words to load; latched on accepted start.
REQ-008 s_data  in  8  byte stream payload, little-endian within each word.
REQ-009 s_valid  in  1  byte available; s_ready  out  1  byte accepted when both high.
REQ-010 CPU_Debug_DataRAM_A2  out  32; CPU_Debug_DataRAM_WD2  out  32; CPU_Debug_DataRAM_WE2  out  4  Data RAM debug write port.
REQ-011 CPU_Debug_InstRAM_A2  out  32; CPU_Debug_InstRAM_WD2  out  32; CPU_Debug_InstRAM_WE2  out  4  Inst RAM debug write port.
REQ-012 core_rst  out  1  active-high reset to RV32Core, driven after loading.
REQ-013 busy  out  1; done  out  1; err  out  1  status.

Function
REQ-014 States: IDLE, LOAD_DATA, LOAD_INST, RST_CORE, DONE.
REQ-015 IDLE/DONE + start: if data_words>BRAMWORDS or inst_words>BRAMWORDS -> err=1, go/stay IDLE; else err=0, clear counters, go LOAD_DATA (LOAD_INST if data_words==0; RST_CORE if both 0).
REQ-016 start while busy is ignored.
REQ-017 s_ready=1 exactly in LOAD_DATA/LOAD_INST; throughput one byte per cycle, no bubbles at word boundaries.
REQ-018 Byte k (0..3) of a word lands in bits [8k+7:8k]; byte counter wraps 3->0.
REQ-019 Cycle after the 4th byte is accepted: WD2=assembled word, A2=4*word_index, WE2=4'b1111 on the active region's port for exactly one cycle; other port WE2=0.
REQ-020 WE2 is 0 in every other cycle; A2/WD2 hold last value when WE2=0.
REQ-021 Word index starts at 0 per region, increments by 1 per write; A2 wraps never (bounded by REQ-015).
REQ-022 After the write of the last data word: -> LOAD_INST (or RST_CORE if inst_words==0); byte counter and index reset to 0.
REQ-023 Bytes arriving in the same cycle as the final region write are accepted only if the next state is a LOAD state.
REQ-024 After the last inst word write: -> RST_CORE; core_rst=1 for exactly CORE_RST_CYCLES cycles, then -> DONE.
REQ-025 busy=1 in LOAD_DATA, LOAD_INST, RST_CORE; done=1 only in DONE, held until next accepted start.
REQ-026 s_valid low mid-word stalls assembly with no state loss.

Reset
REQ-027 CPU_RST_N low, at any time including mid-load: state IDLE, all outputs 0 (core_rst=0, s_ready=0, WE2=0, A2=0, WD2=0, busy/done/err=0), counters cleared; partial word discarded.
REQ-028 First start accepted on the first rising edge after CPU_RST_N deasserts.

Structure
REQ-029 Shared package holds BRAMWORDS default, CORE_RST_CYCLES default, state enum, word-width constants.
REQ-030 One sub-module: byte_to_word_packer (8->32 assembly, byte counter, word-valid pulse); FSM, address counters, reset timer in top.

Verification
REQ-031 start, data_words=2, inst_words=1, bytes 01..0C contiguous -> Data WE2 pulses: A2=0 WD2=04030201, A2=4 WD2=08070605; Inst A2=0 WD2=0C0B0A09; core_rst high 5 cycles; done=1.
REQ-032 data_words=0, inst_words=0 -> no WE2 pulse, core_rst 5 cycles, done=1, s_ready never high.
REQ-033 data_words=4097 -> err=1, busy=0, no writes; next start with 1/1 clears err and loads normally.
REQ-034 s_valid dropped 3 cycles after byte 2 of word 0 -> write delayed 3 cycles, WD2 unchanged from contiguous case.
REQ-035 CPU_RST_N pulsed low after 6 of 8 bytes -> all outputs 0 immediately; restart loads from A2=0 with fresh bytes.
REQ-036 data_words=4096 -> last Data write at A2=0x3FFC, then region switch.
